// File: rtl/seq_bit_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : seq_bit_gen
// Description : Serial bit-sequence transmitter feeding a sequence detector.
//               A pattern word is accepted over a valid/ready handshake and
//               shifted out MSB-first (bit len-1 first), one bit per clock,
//               with a programmable length, repeat count and fixed idle gap
//               of GAP_CYC cycles between repetitions.
// Ports       : clk, rst (sync, active-high)
//               load_valid/load_ready  - pattern handshake
//               load_data/len/rep      - pattern word, bit count, extra reps
//               A, a_valid             - serial bit and its qualifier
//               busy, done             - not-idle flag, end-of-job pulse
//               prbs_mode              - only with SEQ_GEN_PRBS_EN defined
// Option      : SEQ_GEN_PRBS_EN adds a PRBS-7 (x^7+x^6+1) bit source.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bit_gen #(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 6,
    parameter int CNT_W   = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [CNT_W-1:0]  load_rep,
`ifdef SEQ_GEN_PRBS_EN
    input  logic              prbs_mode,
`endif
    output logic              A,
    output logic              a_valid,
    output logic              busy,
    output logic              done
);

    // Gap counter sized so it is at least one bit wide even when GAP_CYC=0.
    localparam int c_GAP_W = $clog2(GAP_CYC + 2);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    localparam logic [LEN_W-1:0]   c_LEN_MAX  = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0]   c_LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_word;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_reps;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_done;

    logic [1:0]         w_state_nxt;
    logic [LEN_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   w_reps_nxt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_last_bit;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_bit;

    // Length clamp is applied once, at acceptance.
    assign w_len_clamped = ((load_len == '0) || (load_len > c_LEN_MAX)) ? c_LEN_MAX : load_len;
    assign w_last_bit    = (r_idx == (r_len - c_LEN_ONE));
    // Shift rather than index so the select width never depends on LEN_W.
    assign w_shifted     = r_word >> (r_len - c_LEN_ONE - r_idx);

`ifdef SEQ_GEN_PRBS_EN
    logic       r_mode;
    logic [6:0] r_lfsr;
    logic [6:0] w_seed;

    assign w_seed = 7'(load_data);
    // The emitted bit is the MSB of the post-step state, i.e. r_lfsr[5] with
    // a left-shifting register: seed 7'h7F then yields 1,1,1,1,1,1,0.
    assign w_bit  = r_mode ? r_lfsr[5] : w_shifted[0];
`else
    assign w_bit  = w_shifted[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_word    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_reps    <= '0;
            r_gap_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_reps    <= w_reps_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_word <= load_data;
                r_len  <= w_len_clamped;
            end
        end
    end

`ifdef SEQ_GEN_PRBS_EN
    // LFSR advances once per SHIFT cycle, holds in GAP, and is only reseeded
    // by a new acceptance, so repetitions continue the same sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_lfsr <= '0;
        end else if (w_accept) begin
            r_mode <= prbs_mode;
            r_lfsr <= (w_seed == 7'd0) ? 7'h7F : w_seed;
        end else if (r_state == c_S_SHIFT) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_reps_nxt  = r_reps;
        w_gap_nxt   = r_gap_cnt;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (load_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_S_SHIFT;
                    w_idx_nxt   = '0;
                    w_reps_nxt  = load_rep;
                end
            end
            c_S_SHIFT: begin
                if (w_last_bit) begin
                    w_idx_nxt = '0;
                    if (r_reps != '0) begin
                        w_reps_nxt = r_reps - c_CNT_ONE;
                        if (GAP_CYC > 0) begin
                            w_state_nxt = c_S_GAP;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = c_S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx + c_LEN_ONE;
                end
            end
            c_S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_S_SHIFT;
                    w_idx_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt + c_GAP_ONE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready = (r_state == c_S_IDLE);
        busy       = (r_state != c_S_IDLE);
        a_valid    = (r_state == c_S_SHIFT);
        A          = (r_state == c_S_SHIFT) & w_bit;
        done       = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_bit_gen
// Description : Directed self-checking bench for seq_bit_gen. Expected serial
//               bits are queued when a pattern is driven and popped whenever
//               the DUT flags a_valid; handshake/timing is checked per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bit_gen;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 6;
    localparam int CNT_W  = 8;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic [LEN_W-1:0]  load_len;
    logic [CNT_W-1:0]  load_rep;
`ifdef SEQ_GEN_PRBS_EN
    logic              prbs_mode;
`endif
    logic              A;
    logic              a_valid;
    logic              busy;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    seq_bit_gen #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W),
        .GAP_CYC(GAP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .load_len  (load_len),
        .load_rep  (load_rep),
`ifdef SEQ_GEN_PRBS_EN
        .prbs_mode (prbs_mode),
`endif
        .A         (A),
        .a_valid   (a_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 ns after the edge, and run the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (a_valid === 1'b1) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_bit", 32'(exp_q.size() != 0), 32'd1);
            else
                check("sb_A", A, exp_q.pop_front());
        end else begin
            check("A_zero_when_invalid", A, 1'b0);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a_valid"},    a_valid,    1'b0);
        check({tag, "_busy"},       busy,       1'b0);
        check({tag, "_done"},       done,       1'b0);
        check({tag, "_load_ready"}, load_ready, 1'b1);
        check({tag, "_A"},          A,          1'b0);
    endtask

    // Present a pattern and queue the bits it must produce.
    task automatic drive_load(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len,
                              input logic [CNT_W-1:0] rep, input int exp_len);
        check("load_ready_at_request", load_ready, 1'b1);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = len;
        load_rep   = rep;
        for (int r = 0; r <= int'(rep); r++)
            for (int i = exp_len - 1; i >= 0; i--)
                exp_q.push_back(d[i]);
    endtask

    // Walk through every cycle from the one after acceptance to done.
    task automatic run_pattern(input string tag, input int len, input int rep, input bit hold);
        int total;
        int pos;
        total = (rep + 1) * len + rep * GAP;
        for (int c = 1; c <= total; c++) begin
            tick();
            if (c == 1 && !hold) load_valid = 1'b0;
            pos = (c - 1) % (len + GAP);
            check({tag, "_a_valid"},    a_valid,    32'(pos < len));
            check({tag, "_busy"},       busy,       1'b1);
            check({tag, "_load_ready"}, load_ready, 1'b0);
            check({tag, "_done_early"}, done,       1'b0);
        end
        tick();
        check({tag, "_done"},           done,       1'b1);
        check({tag, "_busy_at_done"},   busy,       1'b0);
        check({tag, "_ready_at_done"},  load_ready, 1'b1);
        check({tag, "_valid_at_done"},  a_valid,    1'b0);
        check({tag, "_queue_drained"},  exp_q.size(), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_rep   = '0;
`ifdef SEQ_GEN_PRBS_EN
        prbs_mode  = 1'b0;
`endif
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Single 4-bit pattern: 1,1,0,1 then done on cycle 5.
        drive_load(16'h000D, 6'd4, 8'd0, 4);
        run_pattern("single", 4, 0, 1'b0);

        // Three repetitions separated by two idle cycles.
        drive_load(16'h0005, 6'd3, 8'd2, 3);
        run_pattern("rep_gap", 3, 2, 1'b0);

        // Length clamp: 0 and oversize both mean full width.
        drive_load(16'hA5C3, 6'd0, 8'd0, 16);
        run_pattern("clamp_0", 16, 0, 1'b0);
        drive_load(16'hA5C3, 6'd40, 8'd0, 16);
        run_pattern("clamp_40", 16, 0, 1'b0);

        // Minimum length with one repeat.
        drive_load(16'h0001, 6'd1, 8'd1, 1);
        run_pattern("len1_rep1", 1, 1, 1'b0);

        // load_valid held high: only the done cycle may accept the next one.
        drive_load(16'h000D, 6'd4, 8'd0, 4);
        run_pattern("hold_first", 4, 0, 1'b1);
        drive_load(16'h0006, 6'd3, 8'd0, 3);
        run_pattern("hold_second", 3, 0, 1'b0);

        // Two-cycle reset in the middle of a repeating stream.
        drive_load(16'h1234, 6'd16, 8'd3, 16);
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_idle("rst_mid_1");
        tick();
        check_idle("rst_mid_2");
        rst = 1'b0;
        tick();
        check_idle("rst_mid_release");

        // Reset during bit 2, then an immediate fresh load.
        drive_load(16'hA5C3, 6'd16, 8'd0, 16);
        tick();
        load_valid = 1'b0;
        tick();
        check("bit2_visible", a_valid, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check_idle("rst_bit2");
        rst = 1'b0;
        drive_load(16'h000D, 6'd4, 8'd0, 4);
        run_pattern("after_rst", 4, 0, 1'b0);

`ifdef SEQ_GEN_PRBS_EN
        // PRBS-7 from seed 7'h7F: 1,1,1,1,1,1,0.
        check("prbs_ready", load_ready, 1'b1);
        prbs_mode  = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h007F;
        load_len   = 6'd7;
        load_rep   = 8'd0;
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        run_pattern("prbs", 7, 0, 1'b0);
        prbs_mode = 1'b0;
`endif

        tick();
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
